// File: rtl/lfsr_checker.sv
// Self-synchronising checker for a Fibonacci LFSR word stream: seeds a local copy
// from the received data, declares lock after a run of matches, then counts mismatches.
module lfsr_checker #(
  parameter int                 WIDTH    = 4,
  parameter logic [WIDTH-1:0]   TAPS     = 4'b1100,
  parameter int                 LOCK_CNT = 4,
  parameter int                 LOSS_CNT = 3,
  parameter int                 ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic             err_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2,
    UNUSED = 2'd3
  } state_e;

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = $clog2(LOSS_CNT + 1);

  localparam logic [MATCH_W-1:0] LOCK_LAST = MATCH_W'(LOCK_CNT);
  localparam logic [MISS_W-1:0]  LOSS_LAST = MISS_W'(LOSS_CNT);
  localparam logic [ERR_W-1:0]   ERR_MAX   = '1;

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] q);
    return {q[WIDTH-2:0], ^(q & TAPS)};
  endfunction

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   exp_q, exp_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic               locked_q, locked_d;
  logic               err_q, err_d;
  logic               count_err;
  logic [ERR_W-1:0]   cnt_base;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    exp_d     = exp_q;
    match_d   = match_q;
    miss_d    = miss_q;
    count_err = 1'b0;

    if (valid_i) begin
      unique case (state_q)
        HUNT: begin
          // All-zero is the LFSR lockup word; it can never seed a valid sequence.
          if (data_i != '0) begin
            exp_d   = lfsr_next(data_i);
            match_d = '0;
            state_d = VERIFY;
          end
        end

        VERIFY: begin
          if (data_i == exp_q) begin
            match_d = match_q + MATCH_W'(1);
            exp_d   = lfsr_next(data_i);
            if (match_d == LOCK_LAST) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else if (data_i != '0) begin
            exp_d   = lfsr_next(data_i);
            match_d = '0;
          end else begin
            match_d = '0;
            state_d = HUNT;
          end
        end

        LOCKED: begin
          // Flywheel: once locked, received data never reloads the prediction.
          exp_d = lfsr_next(exp_q);
          if (data_i == exp_q) begin
            miss_d = '0;
          end else begin
            count_err = 1'b1;
            miss_d    = miss_q + MISS_W'(1);
            if (miss_d == LOSS_LAST) begin
              state_d = HUNT;
            end
          end
        end

        default: ;
      endcase
    end

    if (state_q == UNUSED) begin
      state_d = HUNT;
    end

    // Clear takes effect first, so a simultaneous error leaves a count of one.
    cnt_base  = clear_i ? '0 : err_cnt_q;
    err_cnt_d = (count_err && (cnt_base != ERR_MAX)) ? cnt_base + ERR_W'(1) : cnt_base;

    locked_d = (state_d == LOCKED);
    err_d    = count_err;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= HUNT;
      exp_q     <= '0;
      match_q   <= '0;
      miss_q    <= '0;
      err_cnt_q <= '0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the pre-edge values computed above.
      state_q   <= state_d;
      exp_q     <= exp_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      err_cnt_q <= err_cnt_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
    end
  end

  assign state_o   = state_q;
  assign locked_o  = locked_q;
  assign err_o     = err_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: two instances share one stimulus stream, one with
// the default 8-bit error counter and one with a 2-bit counter to exercise saturation.
module tb_lfsr_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] data_i = '0;
  logic       valid_i = 1'b0;
  logic       clear_i = 1'b0;

  logic       locked_a, err_a;
  logic [7:0] cnt_a;
  logic [1:0] state_a;
  logic       locked_b, err_b;
  logic [1:0] cnt_b;
  logic [1:0] state_b;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  lfsr_checker dut_a (
    .clk       (clk),
    .reset     (reset),
    .data_i    (data_i),
    .valid_i   (valid_i),
    .clear_i   (clear_i),
    .locked_o  (locked_a),
    .err_o     (err_a),
    .err_cnt_o (cnt_a),
    .state_o   (state_a)
  );

  lfsr_checker #(.ERR_W(2)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .data_i    (data_i),
    .valid_i   (valid_i),
    .clear_i   (clear_i),
    .locked_o  (locked_b),
    .err_o     (err_b),
    .err_cnt_o (cnt_b),
    .state_o   (state_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Outputs of both instances; cnt2 is the 2-bit saturating view of the same errors.
  task automatic expect_out(input string tag, input int st, input int lk, input int er,
                            input int cnt8, input int cnt2);
    chk({tag, ".state"},  32'(state_a),  32'(st));
    chk({tag, ".locked"}, 32'(locked_a), 32'(lk));
    chk({tag, ".err"},    32'(err_a),    32'(er));
    chk({tag, ".cnt8"},   32'(cnt_a),    32'(cnt8));
    chk({tag, ".cnt2"},   32'(cnt_b),    32'(cnt2));
    chk({tag, ".state2"}, 32'(state_b),  32'(st));
    chk({tag, ".err2"},   32'(err_b),    32'(er));
  endtask

  task automatic step(input logic [3:0] d, input logic v, input logic c);
    data_i  = d;
    valid_i = v;
    clear_i = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held low with a valid stream
    step(4'h1, 1'b1, 1'b0); expect_out("rst1", 0, 0, 0, 0, 0);
    step(4'h2, 1'b1, 1'b0); expect_out("rst2", 0, 0, 0, 0, 0);
    step(4'h4, 1'b1, 1'b0); expect_out("rst3", 0, 0, 0, 0, 0);
    reset = 1'b1;

    // Lockup word keeps HUNT
    step(4'h0, 1'b1, 1'b0); expect_out("zero1", 0, 0, 0, 0, 0);
    step(4'h0, 1'b1, 1'b0); expect_out("zero2", 0, 0, 0, 0, 0);
    step(4'h0, 1'b1, 1'b0); expect_out("zero3", 0, 0, 0, 0, 0);

    // Lock with valid gaps carrying junk data
    step(4'h1, 1'b1, 1'b0); expect_out("seed",  1, 0, 0, 0, 0);
    step(4'hF, 1'b0, 1'b0); expect_out("gap1",  1, 0, 0, 0, 0);
    step(4'h2, 1'b1, 1'b0); expect_out("m1",    1, 0, 0, 0, 0);
    step(4'h4, 1'b1, 1'b0); expect_out("m2",    1, 0, 0, 0, 0);
    step(4'h0, 1'b0, 1'b0); expect_out("gap2",  1, 0, 0, 0, 0);
    step(4'h9, 1'b1, 1'b0); expect_out("m3",    1, 0, 0, 0, 0);
    step(4'h3, 1'b1, 1'b0); expect_out("lock",  2, 1, 0, 0, 0);

    // Single error, then singles up to saturation of the 2-bit counter
    step(4'h0, 1'b1, 1'b0); expect_out("e1",    2, 1, 1, 1, 1);
    step(4'hD, 1'b1, 1'b0); expect_out("e1.D",  2, 1, 0, 1, 1);
    step(4'hA, 1'b1, 1'b0); expect_out("e1.A",  2, 1, 0, 1, 1);
    step(4'h0, 1'b0, 1'b0); expect_out("lgap",  2, 1, 0, 1, 1);
    step(4'h5, 1'b1, 1'b0); expect_out("ok5",   2, 1, 0, 1, 1);
    step(4'h0, 1'b1, 1'b0); expect_out("e2",    2, 1, 1, 2, 2);
    step(4'h7, 1'b1, 1'b0); expect_out("ok7",   2, 1, 0, 2, 2);
    step(4'h0, 1'b1, 1'b0); expect_out("e3",    2, 1, 1, 3, 3);
    step(4'hE, 1'b1, 1'b0); expect_out("okE",   2, 1, 0, 3, 3);
    step(4'h0, 1'b1, 1'b0); expect_out("e4",    2, 1, 1, 4, 3);
    step(4'h8, 1'b1, 1'b0); expect_out("ok8",   2, 1, 0, 4, 3);
    step(4'h0, 1'b1, 1'b0); expect_out("e5",    2, 1, 1, 5, 3);
    step(4'h2, 1'b1, 1'b0); expect_out("ok2",   2, 1, 0, 5, 3);

    // Clear with error on the same beat, then clear alone
    step(4'h0, 1'b1, 1'b1); expect_out("clr_err", 2, 1, 1, 1, 1);
    step(4'h9, 1'b1, 1'b1); expect_out("clr",     2, 1, 0, 0, 0);
    step(4'h3, 1'b1, 1'b0); expect_out("ok3",     2, 1, 0, 0, 0);

    // Loss of lock after three consecutive misses
    step(4'h0, 1'b1, 1'b0); expect_out("loss1", 2, 1, 1, 1, 1);
    step(4'h0, 1'b1, 1'b0); expect_out("loss2", 2, 1, 1, 2, 2);
    step(4'h0, 1'b1, 1'b0); expect_out("loss3", 0, 0, 1, 3, 3);

    // Relock, with a wrong word in VERIFY that reseeds without counting
    step(4'h5, 1'b1, 1'b0); expect_out("rl.seed",  1, 0, 0, 3, 3);
    step(4'hB, 1'b1, 1'b0); expect_out("rl.B",     1, 0, 0, 3, 3);
    step(4'h9, 1'b1, 1'b0); expect_out("rl.reseed",1, 0, 0, 3, 3);
    step(4'h3, 1'b1, 1'b0); expect_out("rl.3",     1, 0, 0, 3, 3);
    step(4'h6, 1'b1, 1'b0); expect_out("rl.6",     1, 0, 0, 3, 3);
    step(4'hD, 1'b1, 1'b0); expect_out("rl.D",     1, 0, 0, 3, 3);
    step(4'hA, 1'b1, 1'b0); expect_out("rl.lock",  2, 1, 0, 3, 3);

    // Asynchronous reset while locked with err_o high
    step(4'h0, 1'b1, 1'b0); expect_out("pre_rst", 2, 1, 1, 4, 3);
    reset = 1'b0;
    #1;
    expect_out("async_rst", 0, 0, 0, 0, 0);
    chk("async_rst.locked2", 32'(locked_b), 32'd0);
    step(4'h1, 1'b1, 1'b0); expect_out("rst_hold", 0, 0, 0, 0, 0);
    reset = 1'b1;

    // Back-to-back relock needs seed + 4 matches
    step(4'h1, 1'b1, 1'b0); expect_out("b2b.seed", 1, 0, 0, 0, 0);
    step(4'h2, 1'b1, 1'b0); expect_out("b2b.2",    1, 0, 0, 0, 0);
    step(4'h4, 1'b1, 1'b0); expect_out("b2b.4",    1, 0, 0, 0, 0);
    step(4'h9, 1'b1, 1'b0); expect_out("b2b.9",    1, 0, 0, 0, 0);
    step(4'h3, 1'b1, 1'b0); expect_out("b2b.lock", 2, 1, 0, 0, 0);
    chk("b2b.locked2", 32'(locked_b), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
